// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared encodings for the load/store stage.
//   - mem_op encodings (MEM_NONE / MEM_LD / MEM_ST; 2'b11 is reserved and
//     behaves as MEM_NONE)
//   - funct3 access-size constants (F3_B / F3_H / F3_W / F3_BU / F3_HU)
//   - mem_state_t : state register type for the mem_stage FSM
//   - mem_size_t and helpers that map funct3 to an access size and signedness
// ----------------------------------------------------------------------------
package core_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_LD   = 2'b01;
    localparam logic [1:0] MEM_ST   = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_t;

    // Encodings outside the five defined sizes fall back to a full word.
    function automatic mem_size_t f3_size(input logic [2:0] funct3);
        mem_size_t sz;
        case (funct3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] funct3);
        return (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_stage_ld_align.sv
// ----------------------------------------------------------------------------
// ld_align
// Combinational load-data alignment: picks the byte/halfword lane addressed
// by offset out of the memory word and sign- or zero-extends it to WIDTH.
// Ports:
//   rdata   in  WIDTH  raw word returned by data memory
//   offset  in  2      low address bits of the load
//   funct3  in  3      access size / signedness
//   data    out WIDTH  aligned, extended load value
// ----------------------------------------------------------------------------
module ld_align
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       offset,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        // Halfwords only ever sit in lane 0 or lane 2; offset[0] is ignored.
        half_lane = rdata[{offset[1], 4'b0000} +: 16];
        sext      = ~f3_unsigned(funct3);
        data      = rdata;
        case (f3_size(funct3))
            SZ_B:    data = {{(WIDTH-8){byte_lane[7] & sext}}, byte_lane};
            SZ_H:    data = {{(WIDTH-16){half_lane[15] & sext}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// Load/store stage behind execute. alu_out is the effective address for
// memory ops (and the result for everything else), Rd2 is the store data.
// Memory ops run a req/gnt/rvalid transaction on the data port; the result
// leaves through a valid/ready writeback handshake.
//
// State | meaning
// IDLE  | empty, ready to accept
// REQ   | dmem_req high, bus outputs frozen until dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid
// RESP  | wb_valid high, held until wb_ready (may accept the next op)
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                execute handshake
//   alu_out, Rd2, mem_op, funct3,
//   rd_addr                          instruction from execute
//   dmem_req/we/addr/be/wdata        data-memory request (registered)
//   dmem_gnt, dmem_rvalid, dmem_rdata data-memory response
//   wb_valid/wb_ready, wb_data,
//   wb_rd, wb_exc                    writeback handshake to the register file
//
// Build option: MISALIGN_TRAP_EN -- misaligned h/w accesses skip the bus and
// return wb_exc=1 with the faulting address. Without it the low address bits
// that do not fit the access size are dropped and wb_exc is tied low.
// ----------------------------------------------------------------------------
module mem_stage
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] Rd2,
    input  logic [1:0]       mem_op,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd_addr,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [4:0]       wb_rd,
    output logic             wb_exc
);

    mem_state_t       state_q, state_d;
    mem_state_t       accept_target;

    logic             accept;
    logic             is_ld, is_st, is_mem;
    logic             trap;
    mem_size_t        size_in;
    logic [3:0]       be_in;
    logic [WIDTH-1:0] wdata_in;

    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [3:0]       be_q;
    logic [WIDTH-1:0] wdata_q;
    logic [2:0]       ld_f3_q;
    logic [1:0]       ld_off_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] wb_data_q;
    logic [4:0]       wb_rd_q;
    logic [WIDTH-1:0] ld_data;

    logic             store_done;
    logic             load_done;

    // ------------------------------------------------------------------
    // Incoming instruction decode
    // ------------------------------------------------------------------
    assign is_ld   = (mem_op == MEM_LD);
    assign is_st   = (mem_op == MEM_ST);
    assign is_mem  = is_ld | is_st;
    assign size_in = f3_size(funct3);

`ifdef MISALIGN_TRAP_EN
    assign trap = is_mem &&
                  (((size_in == SZ_H) && alu_out[0]) ||
                   ((size_in == SZ_W) && (alu_out[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = Rd2;
        case (size_in)
            SZ_B: begin
                be_in    = 4'b0001 << alu_out[1:0];
                wdata_in = {(WIDTH/8){Rd2[7:0]}};
            end
            SZ_H: begin
                be_in    = alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_in = {(WIDTH/16){Rd2[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = Rd2;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && wb_ready);
    assign accept   = in_valid && in_ready;

    assign store_done = (state_q == ST_REQ)  && dmem_gnt && we_q;
    assign load_done  = (state_q == ST_WAIT) && dmem_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        accept_target = (is_mem && !trap) ? ST_REQ : ST_RESP;
        state_d       = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = accept_target;
            end
            ST_REQ: begin
                // An rvalid in the grant cycle is deliberately not looked at.
                if (dmem_gnt) state_d = we_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (dmem_rvalid) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (wb_ready) state_d = in_valid ? accept_target : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus request and writeback registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            ld_f3_q   <= 3'b000;
            ld_off_q  <= 2'b00;
            rd_q      <= 5'd0;
            wb_data_q <= '0;
            wb_rd_q   <= 5'd0;
        end else begin
            if (accept) begin
                if (is_mem && !trap) begin
                    we_q     <= is_st;
                    addr_q   <= {alu_out[WIDTH-1:2], 2'b00};
                    be_q     <= be_in;
                    wdata_q  <= wdata_in;
                    ld_f3_q  <= funct3;
                    ld_off_q <= alu_out[1:0];
                    rd_q     <= rd_addr;
                end else begin
                    // Passthrough result, or the faulting address on a trap.
                    wb_data_q <= alu_out;
                    wb_rd_q   <= trap ? 5'd0 : rd_addr;
                end
            end
            if (store_done) begin
                wb_data_q <= '0;
                wb_rd_q   <= 5'd0;
            end
            if (load_done) begin
                wb_data_q <= ld_data;
                wb_rd_q   <= rd_q;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic wb_exc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_exc_q <= 1'b0;
        end else if (accept) begin
            wb_exc_q <= trap;
        end else if (store_done || load_done) begin
            wb_exc_q <= 1'b0;
        end
    end

    assign wb_exc = wb_exc_q;
`else
    assign wb_exc = 1'b0;
`endif

    ld_align #(.WIDTH(WIDTH)) u_ld_align (
        .rdata  (dmem_rdata),
        .offset (ld_off_q),
        .funct3 (ld_f3_q),
        .data   (ld_data)
    );

    assign dmem_req   = (state_q == ST_REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

    assign wb_valid   = (state_q == ST_RESP);
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;

endmodule
